// File: rtl/frame_swap_ctrl_pkg.sv
// rtl/frame_swap_ctrl_pkg.sv - shared display constants and frame swap types
package frame_swap_ctrl_pkg;

    // Display timing constants used across the VGA path.
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Width of the stall-cycle counter.
    localparam int FRAME_SWAP_STALL_W = 24;

    // Width of the hold timer (HOLD_CYCLES legal range 1..255).
    localparam int FRAME_SWAP_HOLD_W = 8;

    typedef enum logic [1:0] {
        RENDER      = 2'd0,
        WAIT_VBLANK = 2'd1,
        SWAP        = 2'd2,
        HOLD        = 2'd3
    } swap_state_t;

endpackage

// File: rtl/frame_swap_ctrl_swap_hold_timer.sv
// rtl/frame_swap_ctrl_swap_hold_timer.sv - loadable down-counter with zero flag
//
// Ports:
//   clk        system clock
//   resetn     synchronous active-low reset (count -> 0)
//   load       load load_value this cycle (takes priority over dec)
//   load_value value to load
//   dec        decrement by one, stopping at zero
//   zero       count is zero
module swap_hold_timer
    import frame_swap_ctrl_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         load,
    input  logic [FRAME_SWAP_HOLD_W-1:0] load_value,
    input  logic                         dec,
    output logic                         zero
);

    logic [FRAME_SWAP_HOLD_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - FRAME_SWAP_HOLD_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/frame_swap_ctrl.sv
// rtl/frame_swap_ctrl.sv - double-buffer swap controller synchronised to vblank
//
// Ports:
//   clk_in, rst_n_in      clock, synchronous active-low reset
//   frame_done_in         renderer finished the write buffer (pulse)
//   vblank_start_in       first cycle of vertical blanking (pulse)
//   swap_out              one-cycle exchange command to the buffer manager
//   which_bram_out        buffer currently displayed
//   write_ready_out       renderer may write / start a new frame
//   frame_pending_out     finished frame waiting for vblank
//   err_out               sticky: frame_done_in seen outside RENDER
//   frames_swapped_out    swap count (wraps)
//   stall_cycles_out      cycles with write_ready_out low (saturates)
// Build option: FRAME_SWAP_STATS_EN enables the two statistics counters;
// without it both statistics outputs are tied to zero.
module frame_swap_ctrl
    import frame_swap_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int FRAMES_W    = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          frame_done_in,
    input  logic                          vblank_start_in,
    output logic                          swap_out,
    output logic                          which_bram_out,
    output logic                          write_ready_out,
    output logic                          frame_pending_out,
    output logic                          err_out,
    output logic [FRAMES_W-1:0]           frames_swapped_out,
    output logic [FRAME_SWAP_STALL_W-1:0] stall_cycles_out
);

    localparam logic [FRAME_SWAP_HOLD_W-1:0] HOLD_LOAD = FRAME_SWAP_HOLD_W'(HOLD_CYCLES - 1);

    swap_state_t state;
    logic        hold_zero;

    // Loaded during SWAP so HOLD starts with HOLD_CYCLES-1 and spends
    // exactly HOLD_CYCLES cycles before returning to RENDER.
    swap_hold_timer u_hold_timer (
        .clk        (clk_in),
        .resetn     (rst_n_in),
        .load       (state == SWAP),
        .load_value (HOLD_LOAD),
        .dec        (state == HOLD),
        .zero       (hold_zero)
    );

    // Outputs are updated together with the state transition so they all
    // come straight from flops.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state             <= RENDER;
            swap_out          <= 1'b0;
            which_bram_out    <= 1'b0;
            write_ready_out   <= 1'b1;
            frame_pending_out <= 1'b0;
            err_out           <= 1'b0;
        end else begin
            swap_out <= 1'b0;
            if (frame_done_in && (state != RENDER)) begin
                err_out <= 1'b1;
            end
            case (state)
                RENDER: begin
                    // A vblank arriving with frame_done is too early to use.
                    if (frame_done_in) begin
                        state             <= WAIT_VBLANK;
                        write_ready_out   <= 1'b0;
                        frame_pending_out <= 1'b1;
                    end
                end
                WAIT_VBLANK: begin
                    if (vblank_start_in) begin
                        state             <= SWAP;
                        swap_out          <= 1'b1;
                        frame_pending_out <= 1'b0;
                    end
                end
                SWAP: begin
                    state          <= HOLD;
                    which_bram_out <= ~which_bram_out;
                end
                HOLD: begin
                    if (hold_zero) begin
                        state           <= RENDER;
                        write_ready_out <= 1'b1;
                    end
                end
                default: state <= RENDER;
            endcase
        end
    end

`ifdef FRAME_SWAP_STATS_EN
    logic [FRAMES_W-1:0]           frames_q;
    logic [FRAME_SWAP_STALL_W-1:0] stall_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            frames_q <= '0;
            stall_q  <= '0;
        end else begin
            if (state == SWAP) begin
                frames_q <= frames_q + FRAMES_W'(1);
            end
            if (!write_ready_out && (stall_q != '1)) begin
                stall_q <= stall_q + FRAME_SWAP_STALL_W'(1);
            end
        end
    end

    assign frames_swapped_out = frames_q;
    assign stall_cycles_out   = stall_q;
`else
    assign frames_swapped_out = '0;
    assign stall_cycles_out   = '0;
`endif

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// tb/tb_frame_swap_ctrl.sv - self-checking bench for frame_swap_ctrl
module tb_frame_swap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fd;
    logic        vb;

    logic        swap_a, which_a, wr_a, pend_a, err_a;
    logic [15:0] frames_a;
    logic [23:0] stall_a;

    logic        swap_b, which_b, wr_b, pend_b, err_b;
    logic [1:0]  frames_b;
    logic [23:0] stall_b;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    frame_swap_ctrl #(.HOLD_CYCLES(4), .FRAMES_W(16)) dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .frame_done_in      (fd),
        .vblank_start_in    (vb),
        .swap_out           (swap_a),
        .which_bram_out     (which_a),
        .write_ready_out    (wr_a),
        .frame_pending_out  (pend_a),
        .err_out            (err_a),
        .frames_swapped_out (frames_a),
        .stall_cycles_out   (stall_a)
    );

    frame_swap_ctrl #(.HOLD_CYCLES(4), .FRAMES_W(2)) dut_w2 (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .frame_done_in      (fd),
        .vblank_start_in    (vb),
        .swap_out           (swap_b),
        .which_bram_out     (which_b),
        .write_ready_out    (wr_b),
        .frame_pending_out  (pend_b),
        .err_out            (err_b),
        .frames_swapped_out (frames_b),
        .stall_cycles_out   (stall_b)
    );

    typedef struct {
        int   c;
        logic fd, vb;
        logic sw, wb, wr, pd, er;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int c, input logic f, input logic v, input logic sw,
                       input logic wb, input logic wr, input logic pd, input logic er);
        vec_t r;
        r.c = c; r.fd = f; r.vb = v; r.sw = sw; r.wb = wb; r.wr = wr; r.pd = pd; r.er = er;
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_frame();
        int k;
        fd = 1'b1; tick(); fd = 1'b0;
        tick(); tick();
        vb = 1'b1; tick(); vb = 1'b0;
        k = 0;
        while (!wr_a && k < 20) begin
            tick();
            k++;
        end
        chk("frame_return_to_render", 32'(wr_a), 32'd1);
    endtask

    int idx;
    int nsw;
    int nlow;
    logic [31:0] exp_frames, exp_frames_w2, exp_stall;

    initial begin
        rst_n = 1'b0; fd = 1'b0; vb = 1'b0;

        //  cycle fd vb | swap which wr pend err
        add(  0, 0, 0,  0, 0, 1, 0, 0);
        add(  5, 0, 1,  0, 0, 1, 0, 0);
        add(  6, 0, 0,  0, 0, 1, 0, 0);
        add( 10, 1, 0,  0, 0, 1, 0, 0);
        add( 11, 0, 0,  0, 0, 0, 1, 0);
        add( 50, 0, 1,  0, 0, 0, 1, 0);
        add( 51, 0, 0,  1, 0, 0, 0, 0);
        add( 52, 0, 0,  0, 1, 0, 0, 0);
        add( 53, 0, 1,  0, 1, 0, 0, 0);
        add( 55, 0, 0,  0, 1, 0, 0, 0);
        add( 56, 0, 0,  0, 1, 1, 0, 0);
        add( 70, 1, 1,  0, 1, 1, 0, 0);
        add( 71, 0, 0,  0, 1, 0, 1, 0);
        add(120, 0, 0,  0, 1, 0, 1, 0);
        add(200, 0, 1,  0, 1, 0, 1, 0);
        add(201, 0, 0,  1, 1, 0, 0, 0);
        add(202, 0, 0,  0, 0, 0, 0, 0);
        add(205, 0, 0,  0, 0, 0, 0, 0);
        add(206, 0, 0,  0, 0, 1, 0, 0);
        add(220, 1, 0,  0, 0, 1, 0, 0);
        add(230, 1, 0,  0, 0, 0, 1, 0);
        add(231, 0, 0,  0, 0, 0, 1, 1);
        add(240, 0, 1,  0, 0, 0, 1, 1);
        add(241, 0, 0,  1, 0, 0, 0, 1);
        add(242, 0, 0,  0, 1, 0, 0, 1);
        add(243, 1, 0,  0, 1, 0, 0, 1);
        add(246, 0, 0,  0, 1, 1, 0, 1);
        add(250, 0, 0,  0, 1, 1, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;

        idx = 0;
        nsw = 0;
        while (cyc <= 250) begin
            fd = 1'b0; vb = 1'b0;
            if (idx < tbl.size() && tbl[idx].c == cyc) begin
                fd = tbl[idx].fd;
                vb = tbl[idx].vb;
                chk("swap_out",          32'(swap_a),  32'(tbl[idx].sw));
                chk("which_bram_out",    32'(which_a), 32'(tbl[idx].wb));
                chk("write_ready_out",   32'(wr_a),    32'(tbl[idx].wr));
                chk("frame_pending_out", 32'(pend_a),  32'(tbl[idx].pd));
                chk("err_out",           32'(err_a),   32'(tbl[idx].er));
                idx++;
            end
            if (swap_a) nsw++;
            tick();
        end
        fd = 1'b0; vb = 1'b0;
        chk("table_vectors_reached", 32'(idx), 32'(tbl.size()));
        chk("swap_pulse_count", 32'(nsw), 32'd3);

`ifdef FRAME_SWAP_STATS_EN
        exp_frames = 32'd3; exp_frames_w2 = 32'd3; exp_stall = 32'd205;
`else
        exp_frames = 32'd0; exp_frames_w2 = 32'd0; exp_stall = 32'd0;
`endif
        chk("frames_swapped_3",    32'(frames_a), exp_frames);
        chk("frames_swapped_w2_3", 32'(frames_b), exp_frames_w2);
        chk("stall_cycles",        32'(stall_a),  exp_stall);
        chk("stall_cycles_w2",     32'(stall_b),  exp_stall);

        // Two more frames: five swaps total, 2-bit counter wraps to 1.
        do_frame();
        do_frame();
`ifdef FRAME_SWAP_STATS_EN
        exp_frames = 32'd5; exp_frames_w2 = 32'd1;
`else
        exp_frames = 32'd0; exp_frames_w2 = 32'd0;
`endif
        chk("frames_swapped_5",    32'(frames_a), exp_frames);
        chk("frames_swapped_wrap", 32'(frames_b), exp_frames_w2);
        chk("which_after_5",       32'(which_a),  32'd1);
        chk("which_w2_after_5",    32'(which_b),  32'd1);

        // Sixth swap brings which back to 0, seventh is interrupted by reset.
        do_frame();
        chk("which_after_6", 32'(which_a), 32'd0);
        fd = 1'b1; tick(); fd = 1'b0;
        tick();
        vb = 1'b1; tick(); vb = 1'b0;
        chk("swap_before_reset", 32'(swap_a), 32'd1);
        tick();
        chk("which_in_hold",  32'(which_a), 32'd1);
        chk("ready_in_hold",  32'(wr_a),    32'd0);
        chk("err_before_rst", 32'(err_a),   32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_swap_out",          32'(swap_a),   32'd0);
        chk("rst_which_bram_out",    32'(which_a),  32'd0);
        chk("rst_write_ready_out",   32'(wr_a),     32'd1);
        chk("rst_frame_pending_out", 32'(pend_a),   32'd0);
        chk("rst_err_out",           32'(err_a),    32'd0);
        chk("rst_frames_swapped",    32'(frames_a), 32'd0);
        chk("rst_stall_cycles",      32'(stall_a),  32'd0);
        nsw = 0;
        nlow = 0;
        repeat (20) begin
            if (swap_a) nsw++;
            if (!wr_a) nlow++;
            tick();
        end
        chk("no_swap_after_reset",  32'(nsw),     32'd0);
        chk("ready_after_reset",    32'(nlow),    32'd0);
        chk("which_stays_0",        32'(which_a), 32'd0);

        do_frame();
        chk("which_after_recovery", 32'(which_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
